// File: rtl/uart_echo_core.sv
// UART loopback: 8N1 frames received on rx_i are queued in a small FIFO and
// retransmitted unchanged on tx_o, all timed from one shared 16x baud tick.
module uart_echo_core #(
    parameter int WORD_BITS      = 8,
    parameter int SAMPLE_TICKS   = 16,
    parameter int BAUD_LIMIT     = 651,
    parameter int BAUD_BITS      = 10,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic tx_o,
    output logic rx_done_o,
    output logic tx_done_o,
    output logic baud_tick_o
);

    localparam int TICK_BITS = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int NBIT_BITS = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int FIFO_DEPTH = 1 << FIFO_ADDR_BITS;

    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(SAMPLE_TICKS - 1);
    localparam logic [TICK_BITS-1:0] TICK_HALF = TICK_BITS'(SAMPLE_TICKS / 2 - 1);
    localparam logic [NBIT_BITS-1:0] BIT_LAST  = NBIT_BITS'(WORD_BITS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef logic [FIFO_ADDR_BITS-1:0] ptr_t;

    logic [BAUD_BITS-1:0] baud_cnt;
    logic                 baud_tick;

    logic [1:0]           rx_sync;
    logic                 rx_bit;
    rx_state_t            rx_state;
    logic [TICK_BITS-1:0] rx_s;
    logic [NBIT_BITS-1:0] rx_n;
    logic [WORD_BITS-1:0] rx_shreg;
    logic                 rx_done;

    logic [WORD_BITS-1:0] fifo_mem [FIFO_DEPTH];
    ptr_t                 wr_ptr;
    ptr_t                 rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic                 fifo_rd;

    tx_state_t            tx_state;
    logic [TICK_BITS-1:0] tx_s;
    logic [NBIT_BITS-1:0] tx_n;
    logic [WORD_BITS-1:0] tx_shreg;
    logic                 tx_reg;
    logic                 tx_done;

    assign baud_tick   = (baud_cnt == BAUD_BITS'(BAUD_LIMIT - 1));
    assign baud_tick_o = baud_tick;

    always_ff @(posedge clk_i) begin
        if (reset_i || baud_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BAUD_BITS'(1);
        end
    end

    // rx_i is asynchronous to clk_i, so it passes through two flops first
    assign rx_bit = rx_sync[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_shreg <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx_i};
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        rx_state <= RX_START;
                        rx_s     <= '0;
                    end
                end
                RX_START: begin
                    if (baud_tick) begin
                        if (rx_s == TICK_HALF) begin
                            if (!rx_bit) begin
                                rx_state <= RX_DATA;
                                rx_s     <= '0;
                                rx_n     <= '0;
                            end else begin
                                rx_state <= RX_IDLE;
                            end
                        end else begin
                            rx_s <= rx_s + TICK_BITS'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_tick) begin
                        if (rx_s == TICK_LAST) begin
                            rx_s     <= '0;
                            rx_shreg <= {rx_bit, rx_shreg[WORD_BITS-1:1]};
                            if (rx_n == BIT_LAST) begin
                                rx_state <= RX_STOP;
                            end else begin
                                rx_n <= rx_n + NBIT_BITS'(1);
                            end
                        end else begin
                            rx_s <= rx_s + TICK_BITS'(1);
                        end
                    end
                end
                RX_STOP: begin
                    // The stop level is never inspected: a low stop bit still delivers the word
                    if (baud_tick) begin
                        if (rx_s == TICK_LAST) begin
                            rx_done  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_s <= rx_s + TICK_BITS'(1);
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_done_o = rx_done;

    // A read only happens when non-empty, so a write into an empty FIFO never collides
    assign fifo_rd = (tx_state == TX_IDLE) && !fifo_empty;
    assign fifo_wr = rx_done && (!fifo_full || fifo_rd);

    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= rx_shreg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            case ({fifo_wr, fifo_rd})
                2'b10: begin
                    wr_ptr     <= wr_ptr + ptr_t'(1);
                    fifo_empty <= 1'b0;
                    fifo_full  <= ((wr_ptr + ptr_t'(1)) == rd_ptr);
                end
                2'b01: begin
                    rd_ptr     <= rd_ptr + ptr_t'(1);
                    fifo_full  <= 1'b0;
                    fifo_empty <= ((rd_ptr + ptr_t'(1)) == wr_ptr);
                end
                2'b11: begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                default: ;
            endcase
        end
    end

    // tx_reg is loaded with the level of the phase being entered, so tx_o is glitch-free
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_shreg <= '0;
            tx_reg   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        tx_shreg <= fifo_mem[rd_ptr];
                        tx_s     <= '0;
                        tx_reg   <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_tick) begin
                        if (tx_s == TICK_LAST) begin
                            tx_s     <= '0;
                            tx_n     <= '0;
                            tx_reg   <= tx_shreg[0];
                            tx_state <= TX_DATA;
                        end else begin
                            tx_s <= tx_s + TICK_BITS'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (baud_tick) begin
                        if (tx_s == TICK_LAST) begin
                            tx_s <= '0;
                            if (tx_n == BIT_LAST) begin
                                tx_reg   <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                tx_n     <= tx_n + NBIT_BITS'(1);
                                tx_shreg <= tx_shreg >> 1;
                                tx_reg   <= tx_shreg[1];
                            end
                        end else begin
                            tx_s <= tx_s + TICK_BITS'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (baud_tick) begin
                        if (tx_s == TICK_LAST) begin
                            tx_done  <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_s <= tx_s + TICK_BITS'(1);
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_o      = tx_reg;
    assign tx_done_o = tx_done;

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core: table of frames driven serially, echoes decoded off tx_o
// and checked against a scoreboard queue, plus glitch, reset and baud-tick sequences.
module tb_uart_echo_core;

    localparam int W          = 8;
    localparam int ST         = 16;
    localparam int BL         = 4;
    localparam int BB         = 2;
    localparam int FA         = 2;
    localparam int BIT_CLKS   = ST * BL;
    localparam int FRAME_CLKS = (W + 2) * BIT_CLKS;

    logic clk_i = 1'b0;
    logic reset_i;
    logic rx_i;
    logic tx_o;
    logic rx_done_o;
    logic tx_done_o;
    logic baud_tick_o;

    int         n_vectors = 0;
    int         n_miscompares = 0;
    int         rx_done_cnt = 0;
    int         tx_done_cnt = 0;
    int         tx_low_cnt = 0;
    bit         mon_busy = 1'b0;
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] data;
        bit         stop_low;
        bit         chain;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs [4];

    uart_echo_core #(
        .WORD_BITS     (W),
        .SAMPLE_TICKS  (ST),
        .BAUD_LIMIT    (BL),
        .BAUD_BITS     (BB),
        .FIFO_ADDR_BITS(FA)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rx_i       (rx_i),
        .tx_o       (tx_o),
        .rx_done_o  (rx_done_o),
        .tx_done_o  (tx_done_o),
        .baud_tick_o(baud_tick_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_done_o === 1'b1) rx_done_cnt++;
        if (tx_done_o === 1'b1) tx_done_cnt++;
        if (tx_o !== 1'b1) tx_low_cnt++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input bit stop_low);
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (BIT_CLKS) @(negedge clk_i);
        for (int k = 0; k < W; k++) begin
            rx_i = data[k];
            repeat (BIT_CLKS) @(negedge clk_i);
        end
        if (stop_low) begin
            rx_i = 1'b0;
            repeat (BIT_CLKS * 3 / 4) @(negedge clk_i);
            rx_i = 1'b1;
            repeat (BIT_CLKS / 4) @(negedge clk_i);
        end else begin
            rx_i = 1'b1;
            repeat (BIT_CLKS) @(negedge clk_i);
        end
    endtask

    task automatic wait_clks(input int n, output bit hit_reset);
        hit_reset = 1'b0;
        repeat (n) begin
            @(negedge clk_i);
            if (reset_i) hit_reset = 1'b1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || mon_busy) && t < 4 * FRAME_CLKS) begin
            @(negedge clk_i);
            t++;
        end
        check_output("drain_in_time", 32'(t < 4 * FRAME_CLKS), 32'd1);
        repeat (BIT_CLKS) @(negedge clk_i);
    endtask

    // Decodes each frame on tx_o at mid-bit points; a reset mid-frame abandons it
    initial begin
        logic       prev;
        logic [7:0] got;
        logic [7:0] exp_word;
        bit         aborted;
        bit         hit;
        prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!reset_i && prev === 1'b1 && tx_o === 1'b0) begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                got      = '0;
                wait_clks(BIT_CLKS / 2 - 1, hit);
                aborted |= hit;
                if (!aborted) check_output("tx_start_bit", 32'(tx_o), 32'd0);
                for (int k = 0; k < W; k++) begin
                    if (!aborted) begin
                        wait_clks(BIT_CLKS, hit);
                        aborted |= hit;
                        got[k] = tx_o;
                    end
                end
                if (!aborted) begin
                    wait_clks(BIT_CLKS, hit);
                    aborted |= hit;
                end
                if (!aborted) begin
                    check_output("tx_stop_bit", 32'(tx_o), 32'd1);
                    if (sb.size() == 0) begin
                        check_output("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        exp_word = sb.pop_front();
                        check_output("echo_data", 32'(got), 32'(exp_word));
                    end
                end
                mon_busy = 1'b0;
            end
            prev = tx_o;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rx0;
        int tx0;
        int low0;
        int pending;
        int cyc;

        vecs[0] = '{8'hCC, 1'b0, 1'b0, 8'hCC};
        vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h55};
        vecs[2] = '{8'hA3, 1'b0, 1'b0, 8'hA3};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};

        reset_i = 1'b1;
        rx_i    = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check_output("reset_tx", 32'(tx_o), 32'd1);
        check_output("reset_rx_done", 32'(rx_done_o), 32'd0);
        check_output("reset_tx_done", 32'(tx_done_o), 32'd0);
        check_output("reset_baud_tick", 32'(baud_tick_o), 32'd0);

        reset_i = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (baud_tick_o !== 1'b1 && cyc < 4 * BL);
        check_output("first_tick_delay", 32'(cyc), 32'(BL - 1));
        repeat (2) begin
            cyc = 0;
            do begin
                @(negedge clk_i);
                cyc++;
            end while (baud_tick_o !== 1'b1 && cyc < 4 * BL);
            check_output("tick_period", 32'(cyc), 32'(BL));
        end

        rx0 = rx_done_cnt;
        tx0 = tx_done_cnt;
        pending = 0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(vecs[i].exp_word);
            apply_stimulus(vecs[i].data, vecs[i].stop_low);
            pending++;
            if (!vecs[i].chain) begin
                wait_drain();
                check_output("rx_done_pulses", 32'(rx_done_cnt - rx0), 32'(pending));
                check_output("tx_done_pulses", 32'(tx_done_cnt - tx0), 32'(pending));
                rx0 = rx_done_cnt;
                tx0 = tx_done_cnt;
                pending = 0;
            end
        end

        // Start-bit glitch of 4 ticks must be rejected at the mid-start sample
        rx0  = rx_done_cnt;
        low0 = tx_low_cnt;
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (4 * BL) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (2 * FRAME_CLKS) @(negedge clk_i);
        check_output("glitch_rx_done", 32'(rx_done_cnt - rx0), 32'd0);
        check_output("glitch_tx_idle", 32'(tx_low_cnt - low0), 32'd0);

        // Reset while 0xF0 is being echoed
        tx0 = tx_done_cnt;
        apply_stimulus(8'hF0, 1'b0);
        repeat (120) @(negedge clk_i);
        check_output("tx_mid_frame", 32'(tx_o), 32'd0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("tx_reset_abort", 32'(tx_o), 32'd1);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        low0 = tx_low_cnt;
        repeat (2 * FRAME_CLKS) @(negedge clk_i);
        check_output("tx_done_after_reset", 32'(tx_done_cnt - tx0), 32'd0);
        check_output("fifo_empty_after_reset", 32'(tx_low_cnt - low0), 32'd0);
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
